// File: rtl/counter_run_sched_pkg.sv
// counter_run_sched_pkg: shared types, default sizes and the
// round-robin index helper for the counter run scheduler.
package counter_run_sched_pkg;

  typedef enum logic {
    IDLE,
    RUN
  } state_e;

  localparam int DEF_NUM_REQ   = 3;
  localparam int DEF_CNT_WIDTH = 4;

  // Candidate index for search step off, starting just after last.
  function automatic int unsigned rr_idx(
    input int unsigned last,
    input int unsigned off,
    input int unsigned n
  );
    return (last + 1 + off) % n;
  endfunction

endpackage

// File: rtl/counter_run_scheduler_if.sv
// counter_run_scheduler_if: request/grant bundle between requesters
// (master) and the scheduler (slave): req, len, gnt, busy, cnt, done, aborted.
interface counter_run_scheduler_if
  import counter_run_sched_pkg::*;
#(
  parameter int NUM_REQ   = DEF_NUM_REQ,
  parameter int CNT_WIDTH = DEF_CNT_WIDTH
);

  logic [NUM_REQ-1:0]           req;
  logic [NUM_REQ*CNT_WIDTH-1:0] len;
  logic [NUM_REQ-1:0]           gnt;
  logic                         busy;
  logic [CNT_WIDTH-1:0]         cnt;
  logic [NUM_REQ-1:0]           done;
  logic                         aborted;

  modport master (
    output req,
    output len,
    input  gnt,
    input  busy,
    input  cnt,
    input  done,
    input  aborted
  );

  modport slave (
    input  req,
    input  len,
    output gnt,
    output busy,
    output cnt,
    output done,
    output aborted
  );

endinterface

// File: rtl/counter_run_scheduler_rr_arbiter.sv
// rr_arbiter: combinational rotating-priority select.
// Ports: req_i, last_i in; one-hot win_o and valid_o out.
module rr_arbiter
  import counter_run_sched_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int IW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IW-1:0]      last_i,
  output logic [NUM_REQ-1:0] win_o,
  output logic               valid_o
);

  logic [IW-1:0] idx;

  always_comb begin
    win_o   = '0;
    valid_o = 1'b0;
    idx     = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = IW'(rr_idx(32'(last_i), k, NUM_REQ));
      if (!valid_o && req_i[idx]) begin
        win_o[idx] = 1'b1;
        valid_o    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/counter_run_scheduler.sv
// counter_run_scheduler: round-robin sharing of one run counter.
// Ports: clk, reset (async, active-high), bus (slave modport).
// Optional macro COUNTER_RUN_SCHED_ABORT_EN: dropping req aborts the run.
module counter_run_scheduler
  import counter_run_sched_pkg::*;
#(
  parameter int NUM_REQ   = DEF_NUM_REQ,
  parameter int CNT_WIDTH = DEF_CNT_WIDTH
) (
  input  logic                     clk,
  input  logic                     reset,
  counter_run_scheduler_if.slave   bus
);

  localparam int IW = $clog2(NUM_REQ);

  state_e               state_q;
  logic [NUM_REQ-1:0]   gnt_q;
  logic [NUM_REQ-1:0]   done_q;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic [CNT_WIDTH-1:0] tgt_q;
  logic [IW-1:0]        last_q;
  logic                 aborted_q;

  logic [NUM_REQ-1:0]   win_oh;
  logic                 win_vld;
  logic [IW-1:0]        win_idx;
  logic [CNT_WIDTH-1:0] win_len;
  logic                 abort_w;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IW      (IW)
  ) u_arb (
    .req_i   (bus.req),
    .last_i  (last_q),
    .win_o   (win_oh),
    .valid_o (win_vld)
  );

  always_comb begin
    win_idx = '0;
    win_len = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_oh[i]) begin
        win_idx = IW'(i);
        win_len = bus.len[i*CNT_WIDTH +: CNT_WIDTH];
      end
    end
  end

`ifdef COUNTER_RUN_SCHED_ABORT_EN
  // Owner no longer requesting its own grant.
  assign abort_w = ~|(bus.req & gnt_q);
`else
  assign abort_w = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      done_q    <= '0;
      cnt_q     <= '0;
      tgt_q     <= '0;
      last_q    <= IW'(NUM_REQ - 1);
      aborted_q <= 1'b0;
    end else begin
      done_q    <= '0;
      aborted_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (win_vld) begin
            gnt_q   <= win_oh;
            cnt_q   <= '0;
            tgt_q   <= win_len;
            last_q  <= win_idx;
            state_q <= RUN;
          end
        end
        RUN: begin
          if (abort_w) begin
            gnt_q     <= '0;
            cnt_q     <= '0;
            aborted_q <= 1'b1;
            state_q   <= IDLE;
          end else if (cnt_q == tgt_q) begin
            gnt_q   <= '0;
            cnt_q   <= '0;
            done_q  <= gnt_q;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.busy    = |gnt_q;
  assign bus.cnt     = cnt_q;
  assign bus.done    = done_q;
  assign bus.aborted = aborted_q;

endmodule

// File: tb/tb_counter_run_scheduler.sv
// tb_counter_run_scheduler: directed table-driven bench plus
// hand sequences for mid-run reset and abort behaviour.
module tb_counter_run_scheduler;

  logic clk;
  logic reset;

  counter_run_scheduler_if #(.NUM_REQ(3), .CNT_WIDTH(4)) bus ();

  counter_run_scheduler #(
    .NUM_REQ   (3),
    .CNT_WIDTH (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [2:0]  req;
    logic [11:0] len;
    logic [2:0]  gnt;
    logic [3:0]  cnt;
    logic [2:0]  done;
  } vec_t;

  vec_t vq[$];
  int   n_chk;
  int   n_fail;

  task automatic add(
    input logic        r,
    input logic [2:0]  rq,
    input logic [11:0] ln,
    input logic [2:0]  g,
    input logic [3:0]  c,
    input logic [2:0]  d
  );
    vq.push_back('{r, rq, ln, g, c, d});
  endtask

  task automatic chk(
    input string       nm,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cyc(
    input logic        r,
    input logic [2:0]  rq,
    input logic [11:0] ln
  );
    reset   = r;
    bus.req = rq;
    bus.len = ln;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(
    input string      nm,
    input logic [2:0] g,
    input logic [3:0] c,
    input logic [2:0] d,
    input logic       ab
  );
    chk({nm, " gnt"},  32'(bus.gnt),     32'(g));
    chk({nm, " cnt"},  32'(bus.cnt),     32'(c));
    chk({nm, " done"}, 32'(bus.done),    32'(d));
    chk({nm, " busy"}, 32'(bus.busy),    32'(|g));
    chk({nm, " abrt"}, 32'(bus.aborted), 32'(ab));
  endtask

  initial begin
    n_chk   = 0;
    n_fail  = 0;
    reset   = 1'b1;
    bus.req = '0;
    bus.len = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_out("reset", 3'b000, 4'd0, 3'b000, 1'b0);

    // single requester, len0=3
    add(1, 3'b000, 12'h000, 3'b000, 4'd0, 3'b000);
    add(0, 3'b001, 12'h003, 3'b001, 4'd0, 3'b000);
    add(0, 3'b001, 12'h003, 3'b001, 4'd1, 3'b000);
    add(0, 3'b001, 12'h003, 3'b001, 4'd2, 3'b000);
    add(0, 3'b001, 12'h003, 3'b001, 4'd3, 3'b000);
    add(0, 3'b001, 12'h003, 3'b000, 4'd0, 3'b001);
    add(0, 3'b000, 12'h000, 3'b000, 4'd0, 3'b000);
    // contention, all len=1
    add(1, 3'b000, 12'h000, 3'b000, 4'd0, 3'b000);
    add(0, 3'b111, 12'h111, 3'b001, 4'd0, 3'b000);
    add(0, 3'b111, 12'h111, 3'b001, 4'd1, 3'b000);
    add(0, 3'b111, 12'h111, 3'b000, 4'd0, 3'b001);
    add(0, 3'b111, 12'h111, 3'b010, 4'd0, 3'b000);
    add(0, 3'b111, 12'h111, 3'b010, 4'd1, 3'b000);
    add(0, 3'b111, 12'h111, 3'b000, 4'd0, 3'b010);
    add(0, 3'b111, 12'h111, 3'b100, 4'd0, 3'b000);
    add(0, 3'b111, 12'h111, 3'b100, 4'd1, 3'b000);
    add(0, 3'b111, 12'h111, 3'b000, 4'd0, 3'b100);
    add(0, 3'b111, 12'h111, 3'b001, 4'd0, 3'b000);
    // fairness after reset
    add(1, 3'b000, 12'h000, 3'b000, 4'd0, 3'b000);
    add(0, 3'b110, 12'h111, 3'b010, 4'd0, 3'b000);
    add(0, 3'b110, 12'h111, 3'b010, 4'd1, 3'b000);
    add(0, 3'b110, 12'h111, 3'b000, 4'd0, 3'b010);
    add(0, 3'b110, 12'h111, 3'b100, 4'd0, 3'b000);
    // boundary: len=0 then len=15
    add(1, 3'b000, 12'h000, 3'b000, 4'd0, 3'b000);
    add(0, 3'b001, 12'h000, 3'b001, 4'd0, 3'b000);
    add(0, 3'b001, 12'h000, 3'b000, 4'd0, 3'b001);
    add(0, 3'b000, 12'h000, 3'b000, 4'd0, 3'b000);
    add(0, 3'b001, 12'h00F, 3'b001, 4'd0, 3'b000);
    for (int c = 1; c <= 15; c++)
      add(0, 3'b001, 12'h00F, 3'b001, 4'(c), 3'b000);
    add(0, 3'b001, 12'h00F, 3'b000, 4'd0, 3'b001);
    add(0, 3'b000, 12'h000, 3'b000, 4'd0, 3'b000);

    foreach (vq[i]) begin
      cyc(vq[i].rst, vq[i].req, vq[i].len);
      chk_out($sformatf("row%0d", i),
              vq[i].gnt, vq[i].cnt, vq[i].done, 1'b0);
    end

    // reset in the middle of a run
    cyc(1, 3'b000, 12'h000);
    cyc(0, 3'b001, 12'h005);
    chk_out("mr0", 3'b001, 4'd0, 3'b000, 1'b0);
    cyc(0, 3'b001, 12'h005);
    cyc(0, 3'b001, 12'h005);
    chk_out("mr2", 3'b001, 4'd2, 3'b000, 1'b0);
    reset = 1'b1;
    #1;
    chk_out("mr_async", 3'b000, 4'd0, 3'b000, 1'b0);
    cyc(1, 3'b011, 12'h011);
    cyc(0, 3'b011, 12'h011);
    chk_out("mr_restart", 3'b001, 4'd0, 3'b000, 1'b0);

    // drop req[1] at cnt=1 of a len=5 run
    cyc(1, 3'b000, 12'h000);
    cyc(0, 3'b110, 12'h050);
    chk_out("ab0", 3'b010, 4'd0, 3'b000, 1'b0);
    cyc(0, 3'b110, 12'h050);
    chk_out("ab1", 3'b010, 4'd1, 3'b000, 1'b0);
`ifdef COUNTER_RUN_SCHED_ABORT_EN
    cyc(0, 3'b100, 12'h050);
    chk_out("ab_pulse", 3'b000, 4'd0, 3'b000, 1'b1);
    cyc(0, 3'b100, 12'h050);
    chk_out("ab_next", 3'b100, 4'd0, 3'b000, 1'b0);
    cyc(0, 3'b100, 12'h050);
    chk_out("ab_done", 3'b000, 4'd0, 3'b100, 1'b0);
`else
    for (int c = 2; c <= 5; c++) begin
      cyc(0, 3'b100, 12'h050);
      chk_out($sformatf("ab_cnt%0d", c), 3'b010, 4'(c), 3'b000, 1'b0);
    end
    cyc(0, 3'b100, 12'h050);
    chk_out("ab_done1", 3'b000, 4'd0, 3'b010, 1'b0);
    cyc(0, 3'b100, 12'h050);
    chk_out("ab_next", 3'b100, 4'd0, 3'b000, 1'b0);
    cyc(0, 3'b100, 12'h050);
    chk_out("ab_done2", 3'b000, 4'd0, 3'b100, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
